// File: rtl/laser_pkg.sv
// Shared types and constants for the laser point scheduler and its SPI DAC shifter.
package laser_pkg;

    // Scheduler sequence states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT_X = 3'd1,
        ST_GAP     = 3'd2,
        ST_SHIFT_Y = 3'd3,
        ST_LATCH   = 3'd4,
        ST_SETTLE  = 3'd5
    } lps_state_e;

    // DAC command frame geometry
    localparam int DAC_FRAME_W = 16;
    localparam int DAC_DATA_W  = 12;

    // BUF=0 (unbuffered ref), GAn=1 (1x gain), SHDNn=1 (output active)
    localparam logic [2:0] DAC_CFG_BITS = 3'b011;

    // Channel select bit: A drives the X galvo, B drives the Y galvo
    localparam logic CH_X = 1'b0;
    localparam logic CH_Y = 1'b1;

    // Build one DAC command word: channel, config bits, then the sample code
    function automatic logic [DAC_FRAME_W-1:0] dac_word(input logic ch,
                                                        input logic [DAC_DATA_W-1:0] code);
        return {ch, DAC_CFG_BITS, code};
    endfunction

endpackage

// File: rtl/spi_dac_shifter.sv
// SPI mode-0 transmitter for one 16-bit DAC command frame, MSB first.
// csn falls with bit15 already on mosi; each bit spends CLK_DIV cycles with
// sclk low then CLK_DIV cycles high. mosi only moves when sclk falls, and csn
// rises together with the 16th falling edge, so csn is low 32*CLK_DIV cycles.
module spi_dac_shifter
    import laser_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DAC_FRAME_W-1:0] word,
    output logic                   done,
    output logic                   csn,
    output logic                   sclk,
    output logic                   mosi
);

    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]        HALF_LAST = 5'd31;

    logic                   active_r;
    logic [DIV_W-1:0]       div_cnt_r;
    logic [4:0]             half_cnt_r;
    logic [DAC_FRAME_W-1:0] shreg_r;
    logic                   csn_r;
    logic                   sclk_r;
    logic                   mosi_r;
    logic                   done_r;

    // Frame sequencer: half-period divider, sclk toggling and bit shifting
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r   <= 1'b0;
            div_cnt_r  <= '0;
            half_cnt_r <= 5'd0;
            shreg_r    <= '0;
            csn_r      <= 1'b1;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!active_r) begin
                if (start) begin
                    active_r   <= 1'b1;
                    div_cnt_r  <= '0;
                    half_cnt_r <= 5'd0;
                    shreg_r    <= word;
                    csn_r      <= 1'b0;
                    sclk_r     <= 1'b0;
                    mosi_r     <= word[DAC_FRAME_W-1];
                end else begin
                    csn_r  <= 1'b1;
                    sclk_r <= 1'b0;
                end
            end else if (div_cnt_r == DIV_LAST) begin
                div_cnt_r  <= '0;
                half_cnt_r <= half_cnt_r + 5'd1;
                if (!half_cnt_r[0]) begin
                    // End of the low half: rising edge, DAC samples mosi here
                    sclk_r <= 1'b1;
                end else begin
                    // End of the high half: falling edge, present next bit
                    sclk_r <= 1'b0;
                    if (half_cnt_r == HALF_LAST) begin
                        active_r <= 1'b0;
                        csn_r    <= 1'b1;
                        mosi_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        mosi_r  <= shreg_r[DAC_FRAME_W-2];
                        shreg_r <= {shreg_r[DAC_FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    assign csn  = csn_r;
    assign sclk = sclk_r;
    assign mosi = mosi_r;
    assign done = done_r;

endmodule

// File: rtl/laser_point_scheduler.sv
// Fixed-rate point pacer for the galvo laser projector. On each point tick it
// takes one point, writes X then Y to the dual DAC, pulses LDAC so both axes
// move together, and keeps the laser dark until the mirrors have settled.
module laser_point_scheduler
    import laser_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int POINT_PERIOD  = 2500,
    parameter int SETTLE_CYCLES = 250,
    parameter int DATA_W        = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pt_valid,
    output logic              pt_ready,
    input  logic [DATA_W-1:0] pt_x,
    input  logic [DATA_W-1:0] pt_y,
    input  logic [2:0]        pt_rgb,
    input  logic              pt_blank,
    output logic              dac_csn,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              dac_latchn,
    output logic [2:0]        laser_rgb,
    output logic              busy,
    output logic              underrun,
    output logic              overrun
);

    localparam int                 TICK_W      = (POINT_PERIOD > 1) ? $clog2(POINT_PERIOD) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(POINT_PERIOD - 1);
    localparam int                 PH_MAX      = (SETTLE_CYCLES > 2 * CLK_DIV) ? SETTLE_CYCLES : 2 * CLK_DIV;
    localparam int                 PH_W        = $clog2(PH_MAX + 1);
    // Y start is issued one cycle early so csn is high exactly 2*CLK_DIV cycles
    localparam logic [PH_W-1:0]    GAP_START   = PH_W'(2 * CLK_DIV - 2);
    localparam logic [PH_W-1:0]    LATCH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]    SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

    lps_state_e             state_r;
    logic [TICK_W-1:0]      tick_cnt_r;
    logic [PH_W-1:0]        ph_cnt_r;
    logic [DATA_W-1:0]      y_r;
    logic [2:0]             rgb_r;
    logic                   blank_r;
    logic [2:0]             laser_rgb_r;
    logic                   latchn_r;
    logic                   underrun_r;
    logic                   overrun_r;

    logic                   tick_s;
    logic                   idle_s;
    logic                   accept_s;
    logic                   settle_end_s;
    logic                   sh_start_s;
    logic [DAC_FRAME_W-1:0] sh_word_s;
    logic                   sh_done_s;

    // Tick decode, point handshake and shifter launch selection
    always_comb begin
        tick_s       = enable && (tick_cnt_r == TICK_LAST);
        idle_s       = (state_r == ST_IDLE);
        pt_ready     = tick_s && idle_s && enable && !reset;
        accept_s     = pt_ready && pt_valid;
        settle_end_s = (state_r == ST_SETTLE) && (ph_cnt_r == SETTLE_LAST);
        sh_start_s   = 1'b0;
        sh_word_s    = dac_word(CH_X, pt_x);
        case (state_r)
            ST_IDLE: begin
                sh_start_s = accept_s;
                sh_word_s  = dac_word(CH_X, pt_x);
            end
            ST_GAP: begin
                sh_start_s = (ph_cnt_r == GAP_START);
                sh_word_s  = dac_word(CH_Y, y_r);
            end
            default: begin
                sh_start_s = 1'b0;
                sh_word_s  = dac_word(CH_Y, y_r);
            end
        endcase
    end

    // Point-rate counter: free-runs 0..POINT_PERIOD-1 while enabled, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r <= '0;
        end else if (!enable || (tick_cnt_r == TICK_LAST)) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Transfer sequencer: X frame, gap, Y frame, LDAC pulse, mirror settle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ph_cnt_r   <= '0;
            y_r        <= '0;
            rgb_r      <= 3'b000;
            blank_r    <= 1'b0;
            latchn_r   <= 1'b1;
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            underrun_r <= tick_s && idle_s && !pt_valid;
            // A tick while busy is dropped; the point in flight keeps going
            overrun_r  <= tick_s && !idle_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        y_r      <= pt_y;
                        rgb_r    <= pt_rgb;
                        blank_r  <= pt_blank;
                        ph_cnt_r <= '0;
                        state_r  <= ST_SHIFT_X;
                    end
                end
                ST_SHIFT_X: begin
                    if (sh_done_s) begin
                        ph_cnt_r <= '0;
                        state_r  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (ph_cnt_r == GAP_START) begin
                        ph_cnt_r <= '0;
                        state_r  <= ST_SHIFT_Y;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                ST_SHIFT_Y: begin
                    if (sh_done_s) begin
                        latchn_r <= 1'b0;
                        ph_cnt_r <= '0;
                        state_r  <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (ph_cnt_r == LATCH_LAST) begin
                        latchn_r <= 1'b1;
                        ph_cnt_r <= '0;
                        state_r  <= ST_SETTLE;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_end_s) begin
                        ph_cnt_r <= '0;
                        state_r  <= ST_IDLE;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_W'(1);
                    end
                end
                default: begin
                    latchn_r <= 1'b1;
                    ph_cnt_r <= '0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Laser colour: dark on every tick taken in IDLE and while disabled, lit after settling
    always_ff @(posedge clk) begin
        if (reset) begin
            laser_rgb_r <= 3'b000;
        end else if (!enable) begin
            laser_rgb_r <= 3'b000;
        end else if (tick_s && idle_s) begin
            laser_rgb_r <= 3'b000;
        end else if (settle_end_s) begin
            laser_rgb_r <= blank_r ? 3'b000 : rgb_r;
        end else begin
            laser_rgb_r <= laser_rgb_r;
        end
    end

    spi_dac_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .start (sh_start_s),
        .word  (sh_word_s),
        .done  (sh_done_s),
        .csn   (dac_csn),
        .sclk  (dac_sclk),
        .mosi  (dac_mosi)
    );

    // Enable gates the beam directly so it goes dark in the cycle enable drops
    assign laser_rgb  = laser_rgb_r & {3{enable}};
    assign dac_latchn = latchn_r;
    assign busy       = !idle_s;
    assign underrun   = underrun_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_laser_point_scheduler.sv
// Directed bench for laser_point_scheduler: SPI frames are decoded from the pins
// and compared against words the bench builds from the points it offers.
module tb_laser_point_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: CLK_DIV=2, POINT_PERIOD=400, SETTLE_CYCLES=20
    logic        reset, enable, pt_valid, pt_blank;
    logic [11:0] pt_x, pt_y;
    logic [2:0]  pt_rgb;
    logic        pt_ready, dac_csn, dac_sclk, dac_mosi, dac_latchn, busy, underrun, overrun;
    logic [2:0]  laser_rgb;

    // Short-period DUT for overrun behaviour: POINT_PERIOD=100
    logic        reset2, enable2, pt_valid2;
    logic        pt_ready2, csn2, sclk2, mosi2, latchn2, busy2, underrun2, overrun2;
    logic [2:0]  laser2;

    laser_point_scheduler #(.CLK_DIV(2), .POINT_PERIOD(400), .SETTLE_CYCLES(20), .DATA_W(12)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_rgb(pt_rgb), .pt_blank(pt_blank),
        .dac_csn(dac_csn), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi), .dac_latchn(dac_latchn),
        .laser_rgb(laser_rgb), .busy(busy), .underrun(underrun), .overrun(overrun)
    );

    laser_point_scheduler #(.CLK_DIV(2), .POINT_PERIOD(100), .SETTLE_CYCLES(20), .DATA_W(12)) dut2 (
        .clk(clk), .reset(reset2), .enable(enable2), .pt_valid(pt_valid2), .pt_ready(pt_ready2),
        .pt_x(12'h456), .pt_y(12'h789), .pt_rgb(3'b010), .pt_blank(1'b0),
        .dac_csn(csn2), .dac_sclk(sclk2), .dac_mosi(mosi2), .dac_latchn(latchn2),
        .laser_rgb(laser2), .busy(busy2), .underrun(underrun2), .overrun(overrun2)
    );

    typedef struct {
        logic [15:0] word;
        int          bits;
        int          fall;
        int          rise;
    } frame_t;

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor state (written only by the monitor process)
    frame_t      frm_q[$];
    logic        csn_q = 1'b1, sclk_q = 1'b0, latchn_q = 1'b1;
    logic [15:0] cur_word = 16'h0;
    int          cur_bits = 0, fall_cyc = 0, fall_cnt = 0;
    int          latch_fall_cyc = 0, latch_rise_cyc = 0, latch_cnt = 0;
    int          acc_cnt = 0, und_cnt = 0, acc2_cnt = 0, ovr2_cnt = 0, und2_cnt = 0;

    // Decode SPI frames on sclk rising edges and count handshake/latch events
    always @(negedge clk) begin
        if (csn_q && !dac_csn) begin
            fall_cyc <= cyc;
            fall_cnt <= fall_cnt + 1;
            cur_bits <= 0;
            cur_word <= 16'h0;
        end else if (!dac_csn && dac_sclk && !sclk_q) begin
            cur_word <= {cur_word[14:0], dac_mosi};
            cur_bits <= cur_bits + 1;
        end
        if (!csn_q && dac_csn) frm_q.push_back('{cur_word, cur_bits, fall_cyc, cyc});
        if (latchn_q && !dac_latchn) latch_fall_cyc <= cyc;
        if (!latchn_q && dac_latchn) begin
            latch_rise_cyc <= cyc;
            latch_cnt      <= latch_cnt + 1;
        end
        if (pt_ready && pt_valid)   acc_cnt  <= acc_cnt + 1;
        if (underrun)               und_cnt  <= und_cnt + 1;
        if (pt_ready2 && pt_valid2) acc2_cnt <= acc2_cnt + 1;
        if (overrun2)               ovr2_cnt <= ovr2_cnt + 1;
        if (underrun2)              und2_cnt <= und2_cnt + 1;
        csn_q    <= dac_csn;
        sclk_q   <= dac_sclk;
        latchn_q <= dac_latchn;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          rd_idx   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offer the current point, push its expected frames when taken, then withdraw it
    task automatic wait_accept(input string tag, input int budget);
        int k = 0;
        while (!(pt_ready && pt_valid) && k < budget) begin
            step();
            k++;
        end
        check({tag, "_accept"}, {31'd0, pt_ready && pt_valid}, 32'd1);
        exp_q.push_back({1'b0, 3'b011, pt_x});
        exp_q.push_back({1'b1, 3'b011, pt_y});
        step();
        pt_valid = 1'b0;
    endtask

    // Wait for two more frames and score them against the expected queue
    task automatic check_frames(input string tag);
        int k = 0;
        logic [15:0] e;
        while (frm_q.size() < rd_idx + 2 && k < 300) begin
            step();
            k++;
        end
        check({tag, "_frames_seen"}, {31'd0, frm_q.size() >= rd_idx + 2}, 32'd1);
        if (frm_q.size() >= rd_idx + 2) begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front();
                check({tag, "_word"}, {16'd0, frm_q[rd_idx + i].word}, {16'd0, e});
                check({tag, "_bits"}, frm_q[rd_idx + i].bits, 32'd16);
                check({tag, "_csn_low"}, frm_q[rd_idx + i].rise - frm_q[rd_idx + i].fall, 32'd64);
            end
            check({tag, "_gap"}, frm_q[rd_idx + 1].fall - frm_q[rd_idx].rise, 32'd4);
            rd_idx += 2;
        end
    endtask

    task automatic wait_laser(input string tag, input logic [2:0] v, input int budget, output int at);
        int k = 0;
        while (laser_rgb !== v && k < budget) begin
            step();
            k++;
        end
        at = cyc;
        check({tag, "_laser_on"}, {29'd0, laser_rgb}, {29'd0, v});
    endtask

    int t_on, snap, snap2, k;
    logic [2:0] lor;

    initial begin
        reset = 1'b1; enable = 1'b0; pt_valid = 1'b0; pt_blank = 1'b0;
        pt_x = 12'h0; pt_y = 12'h0; pt_rgb = 3'b000;
        reset2 = 1'b1; enable2 = 1'b0; pt_valid2 = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_csn", {31'd0, dac_csn}, 32'd1);
        check("rst_sclk", {31'd0, dac_sclk}, 32'd0);
        check("rst_mosi", {31'd0, dac_mosi}, 32'd0);
        check("rst_latchn", {31'd0, dac_latchn}, 32'd1);
        check("rst_laser", {29'd0, laser_rgb}, 32'd0);
        check("rst_ready", {31'd0, pt_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0; reset2 = 1'b0;
        step();

        // Overrun: 100-cycle period is shorter than one 158-cycle sequence
        enable2 = 1'b1; pt_valid2 = 1'b1;
        k = 0;
        while (acc2_cnt < 5 && k < 1200) begin step(); k++; end
        check("ovr_accepts", acc2_cnt, 32'd5);
        check("ovr_overruns", ovr2_cnt, 32'd4);
        check("ovr_underruns", und2_cnt, 32'd0);
        enable2 = 1'b0;

        // Normal point with frames, gap, latch and settle timing
        enable = 1'b1;
        pt_x = 12'hABC; pt_y = 12'h123; pt_rgb = 3'b101; pt_blank = 1'b0; pt_valid = 1'b1;
        wait_accept("p1", 450);
        check("p1_laser_dark", {29'd0, laser_rgb}, 32'd0);
        check("p1_busy", {31'd0, busy}, 32'd1);
        check_frames("p1");
        wait_laser("p1", 3'b101, 100, t_on);
        check("p1_latch_low", latch_rise_cyc - latch_fall_cyc, 32'd4);
        check("p1_settle", t_on - latch_rise_cyc, 32'd20);

        // Underrun: no point at the tick
        snap = und_cnt; snap2 = fall_cnt;
        k = 0;
        while (und_cnt == snap && k < 450) begin step(); k++; end
        check("ur_pulse", {31'd0, underrun}, 32'd1);
        check("ur_laser", {29'd0, laser_rgb}, 32'd0);
        step();
        check("ur_one_cycle", {31'd0, underrun}, 32'd0);
        repeat (80) step();
        check("ur_no_csn", fall_cnt, snap2);
        pt_x = 12'h000; pt_y = 12'hFFF; pt_rgb = 3'b011; pt_valid = 1'b1;
        wait_accept("p2", 450);
        check_frames("p2");
        wait_laser("p2", 3'b011, 100, t_on);

        // Blank point: frames go out, beam stays dark
        pt_x = 12'h555; pt_y = 12'hAAA; pt_rgb = 3'b111; pt_blank = 1'b1; pt_valid = 1'b1;
        snap = latch_cnt;
        wait_accept("p3", 450);
        lor = 3'b000;
        for (int i = 0; i < 200; i++) begin
            lor = lor | laser_rgb;
            step();
        end
        check("p3_latched", {31'd0, latch_cnt > snap}, 32'd1);
        check("p3_dark", {29'd0, lor}, 32'd0);
        check_frames("p3");
        pt_blank = 1'b0;

        // Reset in the middle of the X frame, then a clean resend
        pt_x = 12'hF0F; pt_y = 12'h0F0; pt_rgb = 3'b110; pt_valid = 1'b1;
        wait_accept("p4a", 450);
        k = 0;
        while (cur_bits != 8 && k < 60) begin step(); k++; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_csn", {31'd0, dac_csn}, 32'd1);
        check("mid_rst_sclk", {31'd0, dac_sclk}, 32'd0);
        check("mid_rst_laser", {29'd0, laser_rgb}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_partial", frm_q.size() > rd_idx ? frm_q[rd_idx].bits : -1, 32'd8);
        rd_idx = frm_q.size();
        exp_q.delete();
        pt_valid = 1'b1;
        wait_accept("p4b", 450);
        check_frames("p4b");
        wait_laser("p4b", 3'b110, 100, t_on);

        // Enable dropped during settle
        pt_x = 12'h321; pt_y = 12'h654; pt_rgb = 3'b101; pt_valid = 1'b1;
        snap = latch_cnt;
        wait_accept("p5", 450);
        k = 0;
        while (latch_cnt == snap && k < 200) begin step(); k++; end
        repeat (5) step();
        check("en_busy_settle", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        #1;
        check("en_laser_now", {29'd0, laser_rgb}, 32'd0);
        k = 0;
        while (busy && k < 20) begin step(); k++; end
        check("en_busy_fall", {31'd0, busy}, 32'd0);
        repeat (3) step();
        check("en_laser_stays", {29'd0, laser_rgb}, 32'd0);
        check_frames("p5");
        pt_valid = 1'b1; snap = acc_cnt;
        repeat (500) step();
        check("en_no_ready", acc_cnt, snap);

        // Beam lit, then enable drops: dark at once and after re-enable
        enable = 1'b1;
        pt_x = 12'h7FF; pt_y = 12'h800; pt_rgb = 3'b010;
        wait_accept("p6", 450);
        check_frames("p6");
        wait_laser("p6", 3'b010, 100, t_on);
        enable = 1'b0;
        #1;
        check("p6_off_now", {29'd0, laser_rgb}, 32'd0);
        step();
        enable = 1'b1;
        step();
        step();
        check("p6_off_reenable", {29'd0, laser_rgb}, 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    // Run-time bound
    initial begin
        #1000000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

endmodule
